// File: rtl/slice_regfile_pkg.sv
// Shared constants and index arithmetic for the slice register file.
// Element bounds may be negative or reversed; all math is done in signed int.
package slice_pkg;

    localparam int DEF_MSB = 4;
    localparam int DEF_LSB = 0;

    function automatic int range_lo(input int msb, input int lsb);
        return (msb < lsb) ? msb : lsb;
    endfunction

    function automatic int range_hi(input int msb, input int lsb);
        return (msb < lsb) ? lsb : msb;
    endfunction

    localparam int LO    = range_lo(DEF_MSB, DEF_LSB);
    localparam int HI    = range_hi(DEF_MSB, DEF_LSB);
    localparam int NELEM = HI - LO + 1;

    // Array index touched by slice element j; j=0 is the least significant element.
    function automatic int slice_idx(input int sel, input int j, input int msb,
                                     input int lsb, input int slice, input int down);
        if (msb >= lsb)
            return (down != 0) ? sel - slice + 1 + j : sel + j;
        else
            return (down != 0) ? sel - j : sel + slice - 1 - j;
    endfunction

    function automatic logic idx_in_range(input int idx, input int msb, input int lsb);
        return (idx >= range_lo(msb, lsb)) && (idx <= range_hi(msb, lsb));
    endfunction

endpackage

// File: rtl/slice_regfile_if.sv
// Request/response bundle of the slice register file: write port, read port, cursor.
interface slice_regfile_if #(
    parameter int SEL_W  = 3,
    parameter int SLICE  = 2,
    parameter int ELEM_W = 2
);
    logic                      wr_en;
    logic                      wr_use_cur;
    logic [SEL_W-1:0]          wr_sel;
    logic [SLICE*ELEM_W-1:0]   wr_data;
    logic [SLICE-1:0]          wr_mask;
    logic                      wr_oob;
    logic                      rd_en;
    logic                      rd_use_cur;
    logic [SEL_W-1:0]          rd_sel;
    logic [SLICE*ELEM_W-1:0]   rd_data;
    logic                      rd_valid;
    logic                      rd_oob;
    logic                      cur_load;
    logic [SEL_W-1:0]          cur_val;
    logic                      cur_adv;
    logic [SEL_W-1:0]          cur;

    modport master (
        output wr_en, wr_use_cur, wr_sel, wr_data, wr_mask,
        output rd_en, rd_use_cur, rd_sel,
        output cur_load, cur_val, cur_adv,
        input  wr_oob, rd_data, rd_valid, rd_oob, cur
    );

    modport slave (
        input  wr_en, wr_use_cur, wr_sel, wr_data, wr_mask,
        input  rd_en, rd_use_cur, rd_sel,
        input  cur_load, cur_val, cur_adv,
        output wr_oob, rd_data, rd_valid, rd_oob, cur
    );
endinterface

// File: rtl/slice_regfile_map.sv
// Combinational select decoder: per slice element, the storage offset (index - LO)
// and whether that element lands inside [LO:HI]. Out-of-range offsets are forced to 0.
module slice_map
    import slice_pkg::*;
#(
    parameter int MSB   = 4,
    parameter int LSB   = 0,
    parameter int SLICE = 2,
    parameter int SEL_W = 3,
    parameter int DOWN  = 0,
    parameter int OFF_W = 3
) (
    input  logic [SEL_W-1:0]            i_sel,
    output logic [SLICE-1:0][OFF_W-1:0] o_off,
    output logic [SLICE-1:0]            o_in_range
);

    localparam int LO_IDX = range_lo(MSB, LSB);

    int w_sel;

    // Zero-extend before going signed so large selects never wrap to negative indices.
    assign w_sel = int'({1'b0, i_sel});

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        o_off      = '0;
        o_in_range = '0;
        for (int j = 0; j < SLICE; j++) begin
            o_in_range[j] = idx_in_range(slice_idx(w_sel, j, MSB, LSB, SLICE, DOWN), MSB, LSB);
            if (o_in_range[j])
                o_off[j] = OFF_W'(slice_idx(w_sel, j, MSB, LSB, SLICE, DOWN) - LO_IDX);
        end
    end

endmodule

// File: rtl/slice_regfile.sv
// Clocked element-array register file with one masked slice write port, one
// registered slice read port (read-before-write) and an auto-advancing cursor.
module slice_regfile
    import slice_pkg::*;
#(
    parameter int MSB    = 4,
    parameter int LSB    = 0,
    parameter int ELEM_W = 2,
    parameter int SLICE  = 2,
    parameter int SEL_W  = 3,
    parameter int DOWN   = 0
) (
    input logic           clk,
    input logic           rst,
    slice_regfile_if.slave bus
);

    localparam int LO_IDX  = range_lo(MSB, LSB);
    localparam int HI_IDX  = range_hi(MSB, LSB);
    localparam int N_ELEM  = HI_IDX - LO_IDX + 1;
    localparam int OFF_W   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [SEL_W-1:0] CUR_STEP = SEL_W'(SLICE);

    logic [N_ELEM-1:0][ELEM_W-1:0] r_mem;
    logic [SEL_W-1:0]              r_cur;
    logic [SLICE*ELEM_W-1:0]       r_rd_data;
    logic                          r_rd_valid;
    logic                          r_rd_oob;
    logic                          r_wr_oob;

    logic [SEL_W-1:0]              w_wr_sel;
    logic [SEL_W-1:0]              w_rd_sel;
    logic [SLICE-1:0][OFF_W-1:0]   w_wr_off;
    logic [SLICE-1:0][OFF_W-1:0]   w_rd_off;
    logic [SLICE-1:0]              w_wr_in;
    logic [SLICE-1:0]              w_rd_in;
    logic [SLICE*ELEM_W-1:0]       w_rd_slice;
    logic                          w_wr_any_oob;

    // Cursor-relative accesses see the cursor before this cycle's load/advance.
    assign w_wr_sel = bus.wr_use_cur ? r_cur : bus.wr_sel;
    assign w_rd_sel = bus.rd_use_cur ? r_cur : bus.rd_sel;

    slice_map #(
        .MSB(MSB), .LSB(LSB), .SLICE(SLICE), .SEL_W(SEL_W), .DOWN(DOWN), .OFF_W(OFF_W)
    ) u_wr_map (
        .i_sel      (w_wr_sel),
        .o_off      (w_wr_off),
        .o_in_range (w_wr_in)
    );

    slice_map #(
        .MSB(MSB), .LSB(LSB), .SLICE(SLICE), .SEL_W(SEL_W), .DOWN(DOWN), .OFF_W(OFF_W)
    ) u_rd_map (
        .i_sel      (w_rd_sel),
        .o_off      (w_rd_off),
        .o_in_range (w_rd_in)
    );

    always_comb begin
        w_rd_slice = '0;
        for (int j = 0; j < SLICE; j++) begin
            if (w_rd_in[j])
                w_rd_slice[j*ELEM_W +: ELEM_W] = r_mem[w_rd_off[j]];
        end
    end

    assign w_wr_any_oob = |(bus.wr_mask & ~w_wr_in);

    // NOTE: storage is a small flop array that must read back 0 after reset,
    // so it is cleared on rst like any other register rather than left to a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '0;
        end else if (bus.wr_en) begin
            for (int j = 0; j < SLICE; j++) begin
                if (bus.wr_mask[j] && w_wr_in[j])
                    r_mem[w_wr_off[j]] <= bus.wr_data[j*ELEM_W +: ELEM_W];
            end
        end
    end

    // Read path samples r_mem before the same-edge write lands: read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
            r_wr_oob   <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            r_rd_oob   <= bus.rd_en & ~(&w_rd_in);
            r_wr_oob   <= bus.wr_en & w_wr_any_oob;
            if (bus.rd_en)
                r_rd_data <= w_rd_slice;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cur <= '0;
        else if (bus.cur_load)
            r_cur <= bus.cur_val;
        else if (bus.cur_adv)
            r_cur <= (DOWN != 0) ? r_cur - CUR_STEP : r_cur + CUR_STEP;
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_oob   = r_rd_oob;
    assign bus.wr_oob   = r_wr_oob;
    assign bus.cur      = r_cur;

endmodule

// File: tb/tb_slice_regfile.sv
// Directed bench for slice_regfile: three instances ([4:-2] up, [0:6] big-endian up,
// [4:-2] down) driven from one sequence; read results checked through a scoreboard.
module tb_slice_regfile;

    localparam int SEL_W  = 3;
    localparam int SLICE  = 2;
    localparam int ELEM_W = 2;
    localparam int DW     = SLICE * ELEM_W;
    localparam int NU     = 3;

    typedef struct packed {
        logic             wr_en;
        logic             wr_use_cur;
        logic [SEL_W-1:0] wr_sel;
        logic [DW-1:0]    wr_data;
        logic [SLICE-1:0] wr_mask;
        logic             rd_en;
        logic             rd_use_cur;
        logic [SEL_W-1:0] rd_sel;
        logic             cur_load;
        logic [SEL_W-1:0] cur_val;
        logic             cur_adv;
    } stim_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          oob;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stim_t            st       [NU];
    logic [DW-1:0]    o_rd_data [NU];
    logic             o_rd_valid[NU];
    logic             o_rd_oob  [NU];
    logic             o_wr_oob  [NU];
    logic [SEL_W-1:0] o_cur     [NU];

    exp_t sbq [NU][$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NU; k++) begin : g_u
        slice_regfile_if #(.SEL_W(SEL_W), .SLICE(SLICE), .ELEM_W(ELEM_W)) bus ();

        assign bus.wr_en      = st[k].wr_en;
        assign bus.wr_use_cur = st[k].wr_use_cur;
        assign bus.wr_sel     = st[k].wr_sel;
        assign bus.wr_data    = st[k].wr_data;
        assign bus.wr_mask    = st[k].wr_mask;
        assign bus.rd_en      = st[k].rd_en;
        assign bus.rd_use_cur = st[k].rd_use_cur;
        assign bus.rd_sel     = st[k].rd_sel;
        assign bus.cur_load   = st[k].cur_load;
        assign bus.cur_val    = st[k].cur_val;
        assign bus.cur_adv    = st[k].cur_adv;

        assign o_rd_data[k]  = bus.rd_data;
        assign o_rd_valid[k] = bus.rd_valid;
        assign o_rd_oob[k]   = bus.rd_oob;
        assign o_wr_oob[k]   = bus.wr_oob;
        assign o_cur[k]      = bus.cur;

        if (k == 0) begin : g_dut
            slice_regfile #(.MSB(4), .LSB(-2), .ELEM_W(ELEM_W), .SLICE(SLICE),
                            .SEL_W(SEL_W), .DOWN(0)) u_dut (.clk(clk), .rst(rst), .bus(bus));
        end else if (k == 1) begin : g_dut
            slice_regfile #(.MSB(0), .LSB(6), .ELEM_W(ELEM_W), .SLICE(SLICE),
                            .SEL_W(SEL_W), .DOWN(0)) u_dut (.clk(clk), .rst(rst), .bus(bus));
        end else begin : g_dut
            slice_regfile #(.MSB(4), .LSB(-2), .ELEM_W(ELEM_W), .SLICE(SLICE),
                            .SEL_W(SEL_W), .DOWN(1)) u_dut (.clk(clk), .rst(rst), .bus(bus));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < NU; k++) begin
            st[k].wr_en      = 1'b0;
            st[k].wr_use_cur = 1'b0;
            st[k].rd_en      = 1'b0;
            st[k].rd_use_cur = 1'b0;
            st[k].cur_load   = 1'b0;
            st[k].cur_adv    = 1'b0;
        end
    endtask

    task automatic wr(input int k, input logic [SEL_W-1:0] sel, input logic [DW-1:0] data,
                      input logic [SLICE-1:0] mask);
        st[k].wr_en   = 1'b1;
        st[k].wr_sel  = sel;
        st[k].wr_data = data;
        st[k].wr_mask = mask;
    endtask

    task automatic rd(input int k, input logic [SEL_W-1:0] sel, input logic [DW-1:0] data,
                      input logic oob);
        st[k].rd_en  = 1'b1;
        st[k].rd_sel = sel;
        sbq[k].push_back('{data: data, oob: oob});
    endtask

    // One clock; sample on the falling edge, compare read results, then drop strobes.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NU; k++) begin
            check($sformatf("u%0d rd_valid", k), 32'(o_rd_valid[k]), 32'(sbq[k].size() > 0));
            if (sbq[k].size() > 0) begin
                e = sbq[k].pop_front();
                check($sformatf("u%0d rd_data", k), 32'(o_rd_data[k]), 32'(e.data));
                check($sformatf("u%0d rd_oob", k), 32'(o_rd_oob[k]), 32'(e.oob));
            end
        end
        idle_all();
    endtask

    task automatic check_idle_outputs(input string when);
        for (int k = 0; k < NU; k++) begin
            check($sformatf("%s u%0d rd_data", when, k), 32'(o_rd_data[k]), 32'h0);
            check($sformatf("%s u%0d rd_valid", when, k), 32'(o_rd_valid[k]), 32'h0);
            check($sformatf("%s u%0d rd_oob", when, k), 32'(o_rd_oob[k]), 32'h0);
            check($sformatf("%s u%0d wr_oob", when, k), 32'(o_wr_oob[k]), 32'h0);
            check($sformatf("%s u%0d cur", when, k), 32'(o_cur[k]), 32'h0);
        end
    endtask

    initial begin
        for (int k = 0; k < NU; k++) st[k] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");

        // Unit 0, [4:-2] little-endian, +: slicing
        wr(0, 3'd3, 4'b1101, 2'b11);                cycle();
        check("u0 wr_oob in-range", 32'(o_wr_oob[0]), 32'h0);
        rd(0, 3'd3, 4'b1101, 1'b0);                 cycle();
        wr(0, 3'd4, 4'b1111, 2'b11);
        rd(0, 3'd4, 4'b0011, 1'b1);                 cycle();
        check("u0 wr_oob top edge", 32'(o_wr_oob[0]), 32'h1);
        rd(0, 3'd6, 4'b0000, 1'b1);                 cycle();
        check("u0 wr_oob clears", 32'(o_wr_oob[0]), 32'h0);
        rd(0, 3'd7, 4'b0000, 1'b1);                 cycle();
        wr(0, 3'd0, 4'b1111, 2'b11);                cycle();
        wr(0, 3'd0, 4'b0110, 2'b10);
        rd(0, 3'd0, 4'b1111, 1'b0);                 cycle();
        check("u0 wr_oob mask", 32'(o_wr_oob[0]), 32'h0);
        rd(0, 3'd0, 4'b0111, 1'b0);                 cycle();
        wr(0, 3'd4, 4'b1111, 2'b01);                cycle();
        check("u0 wr_oob masked-off oob", 32'(o_wr_oob[0]), 32'h0);
        check("u0 rd_data hold", 32'(o_rd_data[0]), 32'h7);

        // Unit 0 cursor: wrap, load priority, pre-update use by reads and writes
        st[0].cur_load = 1'b1; st[0].cur_val = 3'd6;  cycle();
        check("u0 cur load", 32'(o_cur[0]), 32'd6);
        st[0].cur_adv = 1'b1;                          cycle();
        check("u0 cur wrap", 32'(o_cur[0]), 32'd0);
        st[0].cur_load = 1'b1; st[0].cur_val = 3'd3; st[0].cur_adv = 1'b1; cycle();
        check("u0 cur load>adv", 32'(o_cur[0]), 32'd3);
        rd(0, 3'd6, 4'b1101, 1'b0); st[0].rd_use_cur = 1'b1; st[0].cur_adv = 1'b1; cycle();
        check("u0 cur adv", 32'(o_cur[0]), 32'd5);
        wr(0, 3'd0, 4'b0000, 2'b11); st[0].wr_use_cur = 1'b1;
        st[0].cur_load = 1'b1; st[0].cur_val = 3'd1;   cycle();
        check("u0 wr_oob via cur", 32'(o_wr_oob[0]), 32'h1);
        check("u0 cur reload", 32'(o_cur[0]), 32'd1);
        wr(0, 3'd4, 4'b0000, 2'b11); st[0].wr_use_cur = 1'b1; st[0].cur_adv = 1'b1; cycle();
        check("u0 cur after wr", 32'(o_cur[0]), 32'd3);
        rd(0, 3'd0, 4'b0011, 1'b0);                 cycle();

        // Unit 1, [0:6] big-endian, +: slicing
        wr(1, 3'd2, 4'b1101, 2'b11);                cycle();
        check("u1 wr_oob in-range", 32'(o_wr_oob[1]), 32'h0);
        rd(1, 3'd2, 4'b1101, 1'b0);                 cycle();
        rd(1, 3'd3, 4'b0100, 1'b0);                 cycle();
        rd(1, 3'd6, 4'b0000, 1'b1);                 cycle();
        wr(1, 3'd6, 4'b1111, 2'b11);                cycle();
        check("u1 wr_oob edge", 32'(o_wr_oob[1]), 32'h1);
        rd(1, 3'd5, 4'b0011, 1'b0);                 cycle();

        // Unit 2, [4:-2] little-endian, -: slicing
        wr(2, 3'd3, 4'b1101, 2'b11);                cycle();
        rd(2, 3'd4, 4'b0011, 1'b0);                 cycle();
        rd(2, 3'd3, 4'b1101, 1'b0);                 cycle();
        wr(2, 3'd0, 4'b1010, 2'b11);                cycle();
        check("u2 wr_oob negative idx", 32'(o_wr_oob[2]), 32'h0);
        rd(2, 3'd0, 4'b1010, 1'b0);                 cycle();
        rd(2, 3'd7, 4'b0000, 1'b1);                 cycle();
        rd(2, 3'd1, 4'b0010, 1'b0);                 cycle();
        st[2].cur_load = 1'b1; st[2].cur_val = 3'd1;  cycle();
        st[2].cur_adv = 1'b1;                          cycle();
        check("u2 cur down wrap", 32'(o_cur[2]), 32'd7);

        // Asynchronous reset between edges kills the in-flight read and clears state
        wr(0, 3'd4, 4'b1111, 2'b11);
        st[0].rd_en = 1'b1; st[0].rd_sel = 3'd3;
        @(posedge clk);
        #1;
        check("pre-rst u0 rd_valid", 32'(o_rd_valid[0]), 32'h1);
        check("pre-rst u0 wr_oob", 32'(o_wr_oob[0]), 32'h1);
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("mid-rst");
        idle_all();
        @(negedge clk);
        rst = 1'b0;
        rd(0, 3'd3, 4'b0000, 1'b0);                 cycle();
        rd(1, 3'd2, 4'b0000, 1'b0);                 cycle();
        rd(2, 3'd0, 4'b0000, 1'b0);                 cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/slice_regfile.md
Name: slice_regfile

Overview:
- Parametrised clocked register file over a packed element array `[MSB:LSB][ELEM_W-1:0]`; either endianness, negative bounds allowed.
- One indexed-slice write port and one indexed-slice read port; slice direction (`+:` or `-:`) fixed by parameter.
- Internal auto-advancing cursor supports streaming slice access.
- Successor to the combinational part-select checks in the frontend unit tests: registered storage, defined out-of-range behaviour, per-element write mask.

Parameters:
- MSB, 4, left bound of element range (may be negative or less than LSB)
- LSB, 0, right bound of element range; MSB<LSB means big-endian
- ELEM_W, 2, bits per element
- SLICE, 2, elements per slice access (1..NELEM)
- SEL_W, 3, width of unsigned select inputs and cursor
- DOWN, 0, 0 = `+:` slicing, 1 = `-:` slicing

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe
- wr_use_cur  in  1  1 = use cursor as write select, 0 = use wr_sel
- wr_sel  in  SEL_W  unsigned write select
- wr_data  in  SLICE*ELEM_W  write slice
- wr_mask  in  SLICE  per-slice-element write enable; bit j qualifies wr_data element j
- wr_oob  out  1  registered; set if any masked element of the last write fell out of range
- rd_en  in  1  read strobe
- rd_use_cur  in  1  1 = use cursor as read select
- rd_sel  in  SEL_W  unsigned read select
- rd_data  out  SLICE*ELEM_W  registered read slice
- rd_valid  out  1  read result valid
- rd_oob  out  1  some element of the read slice was out of range
- cur_load  in  1  load cursor from cur_val
- cur_val  in  SEL_W  cursor load value
- cur_adv  in  1  advance cursor by SLICE
- cur  out  SEL_W  current cursor value

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset state: all storage 0; rd_data 0; rd_valid, rd_oob, wr_oob 0; cur 0.
- Index mapping. s = select zero-extended, treated as signed integer. Slice element j (0 = least significant in wr_data/rd_data) maps to array index idx(j):
  - little-endian (MSB>=LSB), DOWN=0: s+j
  - big-endian, DOWN=0: s+SLICE-1-j
  - little-endian, DOWN=1: s-SLICE+1+j
  - big-endian, DOWN=1: s-j
- In range means min(MSB,LSB) <= idx(j) <= max(MSB,LSB).
- Write: takes effect on the clk edge where wr_en=1.
  - Only elements with wr_mask[j]=1 and in range are written; others are unchanged.
  - wr_oob is updated every cycle: it is 1 the cycle after an enabled write with any masked element out of range, otherwise 0.
- Read: 1-cycle latency. rd_en at edge N gives rd_data, rd_valid=1 and rd_oob after edge N.
  - Out-of-range elements read as 0.
  - rd_valid=0 when rd_en was 0; rd_data then holds its previous value.
- Read/write collision at the same edge: read returns pre-write contents (read-before-write).
- Cursor:
  - cur_load has priority over cur_adv.
  - Advance: cur + SLICE when DOWN=0, cur - SLICE when DOWN=1, modulo 2^SEL_W (wraps silently).
  - Reads and writes using the cursor in the same cycle as a cursor update use the pre-update value.
- Reset asserted mid-operation: state clears immediately (asynchronous); no pending read completes.
- Select values above the range (e.g. sel=7 on [4:-2]) are out of range, never aliased.

Decomposition:
- Package slice_pkg holds:
  - NELEM, LO = min(MSB,LSB), HI = max(MSB,LSB) as constants;
  - function slice_idx(sel, j, msb, lsb, slice, down) returning a signed int;
  - function idx_in_range.
- One sub-module, slice_map: combinational, select -> per-element physical offset and in-range vector. Instantiated twice, once for the write port and once for the read port.

Test Plan:
- [4:-2], ELEM_W=2, SLICE=2, DOWN=0: write sel=3, data 4'b1101, mask 2'b11; read sel=3 next cycle -> rd_data 4'b1101, mem[4]=2'b11, mem[3]=2'b01, rd_valid=1 one cycle after rd_en.
- [0:6] big-endian: write sel=2, data 4'b1101 -> mem[2]=2'b11, mem[3]=2'b01; read sel=2 -> 4'b1101.
- [4:-2]: write sel=4, data 4'b1111 -> mem[4]=2'b11, element 5 dropped, wr_oob=1; read sel=4 -> rd_data 4'b0011, rd_oob=1. Read sel=6 -> 0, rd_oob=1.
- Mask: write sel=0, mask 2'b10 -> only mem[1] changes. Simultaneous read sel=0 at the same edge -> returns old data.
- Cursor, SEL_W=3, SLICE=2: load 6, advance -> cur=0 (wrap). Load and advance in the same cycle -> cur=cur_val.
- Assert rst mid-stream, between edges -> outputs and storage 0 immediately; the read issued the previous edge produces no rd_valid.
